// File: rtl/matmul_pkg.sv
// Shared types and constants for the 3x3 matrix-multiply scheduler.
// Matrices are row-major: element (r,c) sits at index r*MAT_DIM+c.
package matmul_pkg;

    localparam int MAT_DIM   = 3;
    localparam int MAT_ELEMS = 9;

    typedef logic [MAT_ELEMS-1:0][7:0]  mat_in_t;
    typedef logic [MAT_ELEMS-1:0][15:0] mat_out_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/matmul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after
// the pointer, wrapping around to index 0.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = ptr_i;
        for (int k = 0; k < N; k++) begin
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_idx_o  = idx;
                gnt_o[idx] = 1'b1;
            end
            idx = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
        end
    end

endmodule

// File: rtl/matmul_sched.sv
// Round-robin scheduler sharing a single 3x3 matmul engine among NUM_REQ
// requesters, with a watchdog that aborts jobs the engine never completes.
module matmul_sched
    import matmul_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ID_W        = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  mat_in_t [NUM_REQ-1:0]  req_matrix_a,
    input  mat_in_t [NUM_REQ-1:0]  req_matrix_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output mat_out_t               rsp_result,
    output logic                   rsp_err,
    output logic                   eng_start,
    output mat_in_t                eng_matrix_a,
    output mat_in_t                eng_matrix_b,
    input  mat_out_t               eng_result,
    input  logic                   eng_done,
    output logic                   busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    sched_state_t     state_q, state_d;
    logic [PTR_W-1:0] ptr_q,   ptr_d;
    logic [WD_W-1:0]  wdog_q,  wdog_d;
    logic [ID_W-1:0]  id_q,    id_d;
    mat_in_t          a_q,     a_d;
    mat_in_t          b_q,     b_d;
    mat_out_t         res_q,   res_d;
    logic             err_q,   err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (PTR_W)
    ) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wdog_d    = wdog_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        err_d     = err_q;
        req_ready = '0;

        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    // Ready is masked during reset so no requester sees an accept that never lands.
                    req_ready = reset ? '0 : gnt;
                    a_d       = req_matrix_a[gnt_idx];
                    b_d       = req_matrix_b[gnt_idx];
                    id_d      = ID_W'(gnt_idx);
                    ptr_d     = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PTR_W'(1);
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completing engine takes precedence over a simultaneous timeout.
                if (eng_done) begin
                    res_d   = eng_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wdog_q == WD_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wdog_q  <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign eng_start    = (state_q == ISSUE);
    assign rsp_valid    = (state_q == RESP);
    assign busy         = (state_q != IDLE);
    assign rsp_id       = id_q;
    assign rsp_result   = res_q;
    assign rsp_err      = err_q;
    assign eng_matrix_a = a_q;
    assign eng_matrix_b = b_q;

endmodule

// File: tb/tb_matmul_sched.sv
// Directed bench for matmul_sched with a behavioural engine and a scoreboard
// fed at request acceptance and drained at response handshake.
module tb_matmul_sched;
    import matmul_pkg::*;

    localparam int NUM_REQ     = 2;
    localparam int ID_W        = 3;
    localparam int TIMEOUT_CYC = 64;
    localparam int ENG_LAT     = 38;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    mat_in_t [NUM_REQ-1:0] req_matrix_a;
    mat_in_t [NUM_REQ-1:0] req_matrix_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    mat_out_t              rsp_result;
    logic                  rsp_err;
    logic                  eng_start;
    mat_in_t               eng_matrix_a;
    mat_in_t               eng_matrix_b;
    mat_out_t              eng_result;
    logic                  eng_done;
    logic                  busy;

    always #5 clk = ~clk;

    matmul_sched #(
        .NUM_REQ     (NUM_REQ),
        .ID_W        (ID_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_matrix_a (req_matrix_a),
        .req_matrix_b (req_matrix_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_err      (rsp_err),
        .eng_start    (eng_start),
        .eng_matrix_a (eng_matrix_a),
        .eng_matrix_b (eng_matrix_b),
        .eng_result   (eng_result),
        .eng_done     (eng_done),
        .busy         (busy)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_start = 0;

    function automatic mat_out_t mat_mul(mat_in_t a, mat_in_t b);
        mat_out_t r;
        int acc;
        r = '0;
        for (int i = 0; i < MAT_DIM; i++) begin
            for (int j = 0; j < MAT_DIM; j++) begin
                acc = 0;
                for (int k = 0; k < MAT_DIM; k++)
                    acc += int'(a[i*MAT_DIM+k]) * int'(b[k*MAT_DIM+j]);
                r[i*MAT_DIM+j] = acc[15:0];
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Behavioural engine: done rises ENG_LAT edges after the edge sampling start.
    logic eng_stuck;
    logic eng_run;
    int   eng_cnt;
    always @(posedge clk) begin
        if (reset) begin
            eng_done   <= 1'b0;
            eng_run    <= 1'b0;
            eng_cnt    <= 0;
            eng_result <= '0;
        end else if (eng_start) begin
            eng_done <= 1'b0;
            eng_run  <= !eng_stuck;
            eng_cnt  <= ENG_LAT - 1;
        end else if (eng_run) begin
            if (eng_cnt == 0) begin
                eng_done   <= 1'b1;
                eng_run    <= 1'b0;
                eng_result <= mat_mul(eng_matrix_a, eng_matrix_b);
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (eng_start) n_start++;

    typedef struct {
        logic [ID_W-1:0] id;
        mat_out_t        res;
        logic            err;
    } exp_t;
    exp_t sb_q[$];

    int   m_ptr  = 0;
    logic m_busy = 1'b0;

    // Reference scheduler model: predicts grants, pushes expectations, checks responses.
    always @(negedge clk) begin
        int g;
        logic [NUM_REQ-1:0] exp_rdy;
        exp_t e;
        if (reset) begin
            chk("ready_in_reset", req_ready, 0);
            m_busy = 1'b0;
            m_ptr  = 0;
            sb_q.delete();
        end else begin
            chk("busy", busy, m_busy);
            if (!m_busy) begin
                g = -1;
                exp_rdy = '0;
                for (int k = 0; k < NUM_REQ; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
                if (g >= 0) exp_rdy[g] = 1'b1;
                chk("req_ready_grant", req_ready, exp_rdy);
                chk("rsp_valid_idle", rsp_valid, 0);
                if (g >= 0) begin
                    e.id  = ID_W'(g);
                    e.err = eng_stuck;
                    e.res = eng_stuck ? '0 : mat_mul(req_matrix_a[g], req_matrix_b[g]);
                    sb_q.push_back(e);
                    m_ptr  = (g + 1) % NUM_REQ;
                    m_busy = 1'b1;
                end
            end else begin
                chk("req_ready_busy", req_ready, 0);
                if (rsp_valid && rsp_ready) begin
                    chk("sb_nonempty", sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk("sb_rsp_id", rsp_id, e.id);
                        chk("sb_rsp_result", rsp_result, e.res);
                        chk("sb_rsp_err", rsp_err, e.err);
                    end
                    m_busy = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int acc, output int lat);
        lat = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = cyc - acc;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        mat_in_t  ma, mb, mc, md;
        mat_out_t ev, snap_r;
        logic [ID_W-1:0] snap_id;
        bit ok;
        int acc, lat, s0;
        logic [NUM_REQ-1:0] gr;

        reset = 1'b1; req_valid = '0; rsp_ready = 1'b1; eng_stuck = 1'b0;
        req_matrix_a = '0; req_matrix_b = '0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_eng_a", eng_matrix_a, 0);
        chk("rst_eng_b", eng_matrix_b, 0);
        chk("rst_req_ready", req_ready, 0);

        // Single job: identity x [1..9]
        @(posedge clk); #1;
        ma = '0; mb = '0; ev = '0;
        for (int e = 0; e < MAT_ELEMS; e++) begin
            mb[e] = 8'(e + 1);
            ev[e] = 16'(e + 1);
        end
        ma[0] = 8'd1; ma[4] = 8'd1; ma[8] = 8'd1;
        req_matrix_a[0] = ma; req_matrix_b[0] = mb;
        s0 = n_start;
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("single_ready_same_cycle", req_ready, 2'b01);
        acc = cyc;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_rsp(acc, lat);
        chk("single_latency", lat, 41);
        chk("single_rsp_id", rsp_id, 0);
        chk("single_rsp_result", rsp_result, ev);
        chk("single_rsp_err", rsp_err, 0);
        chk("single_start_pulses", n_start - s0, 1);
        @(posedge clk); #1;

        // Contention: both requesters valid with all-2 operands; pointer is 1 after the single job
        for (int e = 0; e < MAT_ELEMS; e++) begin
            ma[e] = 8'd2;
            ev[e] = 16'd12;
        end
        req_matrix_a[0] = ma; req_matrix_b[0] = ma;
        req_matrix_a[1] = ma; req_matrix_b[1] = ma;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            ok = 1'b0;
            gr = '0;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (|req_ready) begin
                    ok = 1'b1;
                    gr = req_ready;
                    break;
                end
            end
            chk("contention_accept", ok, 1);
            chk("contention_grant", gr, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i == 3) begin
                @(posedge clk); #1;
                req_valid = '0;
            end
        end
        wait_rsp(cyc, lat);
        chk("contention_rsp_seen", lat >= 0, 1);
        chk("contention_rsp_id", rsp_id, 0);
        chk("contention_rsp_result", rsp_result, ev);
        @(posedge clk); #1;

        // Backpressure: req1 wins (pointer 1), req0 stays pending behind a stalled response
        for (int e = 0; e < MAT_ELEMS; e++) begin
            mc[e] = 8'(3 * e + 1);
            md[e] = 8'(20 - 2 * e);
            ma[e] = 8'(e + 5);
            mb[e] = 8'(7 * e);
        end
        req_matrix_a[1] = mc; req_matrix_b[1] = md;
        req_matrix_a[0] = ma; req_matrix_b[0] = mb;
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        wait_ready(1, ok);
        chk("bp_accept1", ok, 1);
        acc = cyc;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp(acc, lat);
        chk("bp_rsp_seen", lat >= 0, 1);
        snap_r  = rsp_result;
        snap_id = rsp_id;
        chk("bp_rsp_id", snap_id, 1);
        chk("bp_rsp_result", snap_r, mat_mul(mc, md));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_result", rsp_result, snap_r);
            chk("bp_hold_id", rsp_id, snap_id);
            chk("bp_no_accept", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_resume_accept", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_rsp(cyc, lat);
        chk("bp_second_rsp_id", rsp_id, 0);
        @(posedge clk); #1;

        // Overflow passthrough: all-255 operands from req1
        for (int e = 0; e < MAT_ELEMS; e++) begin
            ma[e] = 8'd255;
            ev[e] = 16'd64003;
        end
        req_matrix_a[1] = ma; req_matrix_b[1] = ma;
        req_valid[1] = 1'b1;
        wait_ready(1, ok);
        chk("ovf_accept", ok, 1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp(cyc, lat);
        chk("ovf_rsp_result", rsp_result, ev);
        chk("ovf_rsp_err", rsp_err, 0);
        @(posedge clk); #1;

        // Watchdog: engine never completes
        eng_stuck = 1'b1;
        req_matrix_a[0] = mc; req_matrix_b[0] = md;
        req_valid[0] = 1'b1;
        wait_ready(0, ok);
        chk("wd_accept", ok, 1);
        acc = cyc;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_rsp(acc, lat);
        chk("wd_latency", lat, 2 + TIMEOUT_CYC);
        chk("wd_rsp_err", rsp_err, 1);
        chk("wd_rsp_result", rsp_result, 0);
        chk("wd_rsp_id", rsp_id, 0);
        @(posedge clk); #1;
        eng_stuck = 1'b0;
        req_matrix_a[1] = mc; req_matrix_b[1] = md;
        req_valid[1] = 1'b1;
        wait_ready(1, ok);
        chk("wd_next_accept", ok, 1);
        acc = cyc;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp(acc, lat);
        chk("wd_next_latency", lat, 41);
        chk("wd_next_result", rsp_result, mat_mul(mc, md));
        chk("wd_next_err", rsp_err, 0);
        @(posedge clk); #1;

        // Reset mid-WAIT: job from req0 dropped, pointer returns to 0
        req_valid[0] = 1'b1;
        wait_ready(0, ok);
        chk("rstw_accept", ok, 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        tick(10);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("rstw_busy", busy, 0);
        chk("rstw_rsp_valid", rsp_valid, 0);
        chk("rstw_eng_start", eng_start, 0);
        chk("rstw_rsp_result", rsp_result, 0);
        chk("rstw_rsp_err", rsp_err, 0);
        chk("rstw_eng_a", eng_matrix_a, 0);
        s0 = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid) s0++;
        end
        chk("rstw_no_response", s0, 0);
        @(posedge clk); #1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("rstw_ptr_reset_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(cyc, lat);
        chk("rstw_rsp_id", rsp_id, 0);
        tick(2);
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
